// File: rtl/tick_debouncer.sv
// Debounces a raw asynchronous input using an external sample strobe.
// A level change is accepted after DB_TICKS consecutive qualified samples at the new level.
module tick_debouncer #(
    parameter int DB_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       stable,
    input  logic       btn_in,
    output logic       btn_db,
    output logic       rise,
    output logic       fall,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        LO      = 2'd0,
        WAIT_HI = 2'd1,
        HI      = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DB_TICKS - 1);

    logic       sync_a;
    logic       sync_b;
    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic       rise_n;
    logic       fall_n;
    logic       btn_db_n;
    logic       busy_n;
    logic       qual;

    // tick is a one-cycle strobe; it only counts as a sample while stable is high.
    assign qual      = tick & stable;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            state  <= LO;
            cnt    <= 8'd0;
            btn_db <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
            state  <= state_n;
            cnt    <= cnt_n;
            btn_db <= btn_db_n;
            rise   <= rise_n;
            fall   <= fall_n;
            busy   <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        if (!stable) begin
            // Losing the tick source abandons any pending change; the level holds.
            if (state == WAIT_HI) begin
                state_n = LO;
                cnt_n   = 8'd0;
            end else if (state == WAIT_LO) begin
                state_n = HI;
                cnt_n   = 8'd0;
            end
        end else if (qual) begin
            case (state)
                LO: begin
                    if (sync_b) begin
                        if (DB_TICKS == 1) begin
                            state_n = HI;
                            rise_n  = 1'b1;
                        end else begin
                            state_n = WAIT_HI;
                            cnt_n   = 8'd1;
                        end
                    end
                end
                WAIT_HI: begin
                    if (!sync_b) begin
                        state_n = LO;
                        cnt_n   = 8'd0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = HI;
                        cnt_n   = 8'd0;
                        rise_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                HI: begin
                    if (!sync_b) begin
                        if (DB_TICKS == 1) begin
                            state_n = LO;
                            fall_n  = 1'b1;
                        end else begin
                            state_n = WAIT_LO;
                            cnt_n   = 8'd1;
                        end
                    end
                end
                WAIT_LO: begin
                    if (sync_b) begin
                        state_n = HI;
                        cnt_n   = 8'd0;
                    end else if (cnt == CNT_LAST) begin
                        state_n = LO;
                        cnt_n   = 8'd0;
                        fall_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                default: begin
                    state_n = LO;
                    cnt_n   = 8'd0;
                end
            endcase
        end
        btn_db_n = (state_n == HI) || (state_n == WAIT_LO);
        busy_n   = (state_n == WAIT_HI) || (state_n == WAIT_LO);
    end

endmodule

// File: tb/tb_tick_debouncer.sv
// Bench for tick_debouncer: table of tick-driven steps, pulse scoreboard, and
// hand-written reset / stable-drop / DB_TICKS=1 sequences.
module tb_tick_debouncer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       stable;
    logic       btn_in;
    logic       btn_db4, rise4, fall4, busy4;
    logic       btn_db1, rise1, fall1, busy1;
    logic [1:0] state4, state1;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic       busy1_seen = 1'b0;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P_RISE = 2'b01;
    localparam logic [1:0] P_FALL = 2'b10;

    typedef struct {
        logic       btn;
        logic       stb;
        int         ticks;
        logic       exp_db;
        logic       exp_busy;
        logic [1:0] exp_pulse;
    } vec_t;

    vec_t vecs[21];

    tick_debouncer #(.DB_TICKS(4)) dut4 (
        .clk(clk), .reset(reset), .tick(tick), .stable(stable), .btn_in(btn_in),
        .btn_db(btn_db4), .rise(rise4), .fall(fall4), .busy(busy4), .state_dbg(state4)
    );

    tick_debouncer #(.DB_TICKS(1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .stable(stable), .btn_in(btn_in),
        .btn_db(btn_db1), .rise(rise1), .fall(fall1), .busy(busy1), .state_dbg(state1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One tick period = 27 idle clocks then a 1-clock tick. With bounce set, btn_in
    // toggles randomly early in the idle window and settles 4 clocks before the tick.
    task automatic run_ticks(input int n, input logic b, input logic bounce);
        repeat (n) begin
            for (int i = 0; i < 27; i++) begin
                if (bounce && i < 23) btn_in = 1'($urandom_range(0, 1));
                else btn_in = b;
                @(negedge clk);
            end
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    // scoreboard: every observed pulse on the DB_TICKS=4 instance must match the queue head
    always @(negedge clk) begin
        if (busy1 === 1'b1) busy1_seen = 1'b1;
        if (rise4 === 1'b1 || fall4 === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got rise=%0b fall=%0b expected none at %0t",
                         rise4, fall4, $time);
            end else begin
                chk("pulse", {6'd0, fall4, rise4}, {6'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1, 1'b0, 1'b1, P_NONE};
        vecs[1]  = '{1'b1, 1'b1, 2, 1'b0, 1'b1, P_NONE};
        vecs[2]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, P_RISE};
        vecs[3]  = '{1'b0, 1'b1, 3, 1'b1, 1'b1, P_NONE};
        vecs[4]  = '{1'b0, 1'b1, 1, 1'b0, 1'b0, P_FALL};
        vecs[5]  = '{1'b1, 1'b1, 2, 1'b0, 1'b1, P_NONE};
        vecs[6]  = '{1'b0, 1'b1, 1, 1'b0, 1'b0, P_NONE};
        vecs[7]  = '{1'b1, 1'b1, 3, 1'b0, 1'b1, P_NONE};
        vecs[8]  = '{1'b1, 1'b1, 1, 1'b1, 1'b0, P_RISE};
        vecs[9]  = '{1'b0, 1'b1, 2, 1'b1, 1'b1, P_NONE};
        vecs[10] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, P_NONE};
        vecs[11] = '{1'b0, 1'b1, 4, 1'b0, 1'b0, P_FALL};
        vecs[12] = '{1'b0, 1'b1, 2, 1'b0, 1'b0, P_NONE};
        vecs[13] = '{1'b1, 1'b1, 2, 1'b0, 1'b1, P_NONE};
        vecs[14] = '{1'b1, 1'b0, 2, 1'b0, 1'b0, P_NONE};
        vecs[15] = '{1'b1, 1'b1, 3, 1'b0, 1'b1, P_NONE};
        vecs[16] = '{1'b1, 1'b1, 1, 1'b1, 1'b0, P_RISE};
        vecs[17] = '{1'b0, 1'b1, 2, 1'b1, 1'b1, P_NONE};
        vecs[18] = '{1'b0, 1'b0, 1, 1'b1, 1'b0, P_NONE};
        vecs[19] = '{1'b0, 1'b1, 3, 1'b1, 1'b1, P_NONE};
        vecs[20] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, P_FALL};

        // reset held with btn_in high and a tick in the window
        reset  = 1'b0;
        tick   = 1'b0;
        stable = 1'b1;
        btn_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_db", {7'd0, btn_db4}, 8'd0);
            chk("rst_rise", {7'd0, rise4}, 8'd0);
            chk("rst_fall", {7'd0, fall4}, 8'd0);
            chk("rst_busy", {7'd0, busy4}, 8'd0);
            tick = (i == 2);
        end
        tick   = 1'b0;
        btn_in = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 21; v++) begin
            stable = vecs[v].stb;
            if (vecs[v].exp_pulse != P_NONE) exp_q.push_back(vecs[v].exp_pulse);
            run_ticks(vecs[v].ticks, vecs[v].btn, 1'b1);
            chk($sformatf("v%0d_db", v), {7'd0, btn_db4}, {7'd0, vecs[v].exp_db});
            chk($sformatf("v%0d_busy", v), {7'd0, busy4}, {7'd0, vecs[v].exp_busy});
        end
        stable = 1'b1;

        // reset in the middle of WAIT_HI
        run_ticks(2, 1'b1, 1'b0);
        chk("midwait_busy", {7'd0, busy4}, 8'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midwait_rst_busy", {7'd0, busy4}, 8'd0);
        chk("midwait_rst_state", {6'd0, state4}, 8'd0);

        // full count restarts from zero after the reset
        run_ticks(3, 1'b1, 1'b0);
        chk("restart_db", {7'd0, btn_db4}, 8'd0);
        exp_q.push_back(P_RISE);
        run_ticks(1, 1'b1, 1'b0);
        chk("restart_acc_db", {7'd0, btn_db4}, 8'd1);

        // reset while high: level forced low, no fall pulse
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("hi_rst_db", {7'd0, btn_db4}, 8'd0);
        chk("hi_rst_fall", {7'd0, fall4}, 8'd0);

        // DB_TICKS=1 instance accepts on the first qualified tick
        run_ticks(1, 1'b1, 1'b0);
        chk("db1_db", {7'd0, btn_db1}, 8'd1);
        chk("db1_rise", {7'd0, rise1}, 8'd1);
        chk("db1_busy", {7'd0, busy1}, 8'd0);
        chk("db4_same_tick_busy", {7'd0, busy4}, 8'd1);
        @(negedge clk);
        chk("db1_rise_clear", {7'd0, rise1}, 8'd0);
        run_ticks(1, 1'b0, 1'b0);
        chk("db1_release_db", {7'd0, btn_db1}, 8'd0);
        chk("db1_fall", {7'd0, fall1}, 8'd1);
        chk("db1_busy_never", {7'd0, busy1_seen}, 8'd0);

        repeat (3) @(negedge clk);
        chk("sb_queue_empty", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
